// File: rtl/face_result_uart_tx.sv
// face_result_uart_tx: buffers face detections in a small FIFO and sends
// each one as a 6-byte 8N1 record on a single UART TX line.
// Record: FA, {ovf,000,pyr}, row[15:8], row[7:0], col[15:8], col[7:0].
module face_result_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0][31:0] face_coords,
   input  logic             face_coords_ready,
   input  logic [3:0]       pyramid_number,
   output logic             tx,
   output logic             busy,
   output logic             overflow
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   // FIFO entry: {pyramid[35:32], row[31:16], col[15:0]}
   logic [35:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          ready_q;
   logic          overflow_q, overflow_d;
   logic          push, pop, full, accept, drop;
   logic [35:0]   entry, head;
   logic [47:0]   load_vec;

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [2:0]    byte_idx_q, byte_idx_d;
   logic [47:0]   shreg_q, shreg_d;
   logic          tx_q, tx_d;
   logic          last_tick;

   // Only the low 16 bits of each coordinate are sent.
   logic unused_upper;
   assign unused_upper = ^{face_coords[0][31:16], face_coords[1][31:16]};

   assign push   = face_coords_ready & ~ready_q & ~reset;
   assign full   = (count_q == CW'(FIFO_DEPTH));
   // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
   assign accept = push & (~full | pop);
   assign drop   = push & full & ~pop;
   assign entry  = {pyramid_number, face_coords[0][15:0], face_coords[1][15:0]};
   assign head   = mem_q[rd_ptr_q];
   // Byte 0 sits in the low bits; the register shifts right one bit per bit time.
   assign load_vec = {head[7:0], head[15:8], head[23:16], head[31:24],
                      overflow_q, 3'b000, head[35:32], 8'hFA};

   assign last_tick = (timer_q == TW'(CLKS_PER_BIT - 1));

   assign tx       = tx_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != IDLE) | (count_q != '0);

   // Edge detector follows the input even in reset so a held level never pushes.
   always_ff @(posedge clock) ready_q <= face_coords_ready;

   // FIFO storage needs no reset; validity is tracked by count.
   always_ff @(posedge clock)
      if (accept) mem_q[wr_ptr_q] <= entry;

   // FIFO occupancy and sticky overflow next-state.
   always_comb begin
      count_d = count_q;
      if (accept && !pop)      count_d = count_q + CW'(1);
      else if (!accept && pop) count_d = count_q - CW'(1);
      overflow_d = overflow_q;
      if (pop && overflow_q) overflow_d = 1'b0;
      if (drop)              overflow_d = 1'b1;
   end

   // FIFO pointers, count and overflow flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Transmit FSM state and counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         shreg_q    <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         shreg_q    <= shreg_d;
         tx_q       <= tx_d;
      end
   end

   // Next-state logic; tx_d is the line level for the cycle being entered.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      shreg_d    = shreg_q;
      tx_d       = tx_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (count_q != '0) begin
               pop        = 1'b1;
               shreg_d    = load_vec;
               byte_idx_d = '0;
               timer_d    = '0;
               state_d    = START;
               tx_d       = 1'b0;
            end
         end
         START: begin
            if (last_tick) begin
               timer_d   = '0;
               bit_idx_d = '0;
               state_d   = DATA;
               tx_d      = shreg_q[0];
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         DATA: begin
            if (last_tick) begin
               timer_d = '0;
               shreg_d = shreg_q >> 1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shreg_q[1];
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         STOP: begin
            if (last_tick) begin
               timer_d = '0;
               if (byte_idx_q < 3'd5) begin
                  byte_idx_d = byte_idx_q + 3'd1;
                  state_d    = START;
                  tx_d       = 1'b0;
               end else if (count_q != '0) begin
                  // Next record follows with no idle bit in between.
                  pop        = 1'b1;
                  shreg_d    = load_vec;
                  byte_idx_d = '0;
                  state_d    = START;
                  tx_d       = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_face_result_uart_tx.sv
// Bench for face_result_uart_tx: a UART receiver decodes tx into bytes and
// compares them with records built from each accepted detection.
module tb_face_result_uart_tx;
   localparam int CPB   = 4;
   localparam int DEPTH = 8;
   localparam int BYTE_CYC = 10 * CPB;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [1:0][31:0] face_coords = '0;
   logic             face_coords_ready = 1'b0;
   logic [3:0]       pyramid_number = '0;
   logic             tx, busy, overflow;

   int tests = 0;
   int fails = 0;
   int pcnt  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         rx_t[$];

   face_result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .face_coords(face_coords),
      .face_coords_ready(face_coords_ready), .pyramid_number(pyramid_number),
      .tx(tx), .busy(busy), .overflow(overflow));

   always #5 clock = ~clock;

   initial forever begin
      @(posedge clock);
      pcnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // UART receiver: samples each bit at its centre, records byte start cycle.
   initial begin : rx_mon
      int off;
      int st;
      logic [7:0] b;
      off = -1;
      st  = 0;
      b   = '0;
      forever begin
         @(negedge clock);
         if (reset) off = -1;
         else if (off < 0) begin
            if (tx === 1'b0) begin
               off = 1;
               st  = pcnt;
            end
         end else begin
            if (off >= CPB + CPB/2 && off < 9*CPB && ((off - CPB/2) % CPB) == 0)
               b[(off - CPB/2)/CPB - 1] = tx;
            if (off == 9*CPB + CPB/2) begin
               chk("stop_bit", tx, 1);
               rx_q.push_back(b);
               rx_t.push_back(st);
               off = -1;
            end else off++;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic void add_rec(input logic [31:0] row, input logic [31:0] col,
                                   input logic [3:0] p, input logic o);
      exp_q.push_back(8'hFA);
      exp_q.push_back({o, 3'b000, p});
      exp_q.push_back(row[15:8]);
      exp_q.push_back(row[7:0]);
      exp_q.push_back(col[15:8]);
      exp_q.push_back(col[7:0]);
   endfunction

   task automatic pulse(input logic [31:0] row, input logic [31:0] col,
                        input logic [3:0] p, input int hold);
      face_coords[0]    = row;
      face_coords[1]    = col;
      pyramid_number    = p;
      face_coords_ready = 1'b1;
      repeat (hold) tick();
      face_coords_ready = 1'b0;
      tick();
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      @(negedge clock);
      while (busy !== 1'b0 && k < 5000) begin
         @(negedge clock);
         k++;
      end
      chk({tag, "_timeout"}, (k >= 5000), 0);
      repeat (2) @(negedge clock);
   endtask

   task automatic check_rx(input string tag);
      int n;
      chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
      rx_q.delete();
      rx_t.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [31:0] r, c;
      logic [3:0]  p;
      int k, zeros, s;

      // reset state
      repeat (3) tick();
      @(negedge clock);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      tick();
      reset = 1'b0;
      repeat (2) tick();

      // single detection with latency and record length
      face_coords[0] = 32'd37;
      face_coords[1] = 32'd112;
      pyramid_number = 4'd3;
      face_coords_ready = 1'b1;
      add_rec(32'd37, 32'd112, 4'd3, 1'b0);
      @(negedge clock);
      chk("s1_tx_n", tx, 1);
      chk("s1_busy_n", busy, 0);
      @(negedge clock);
      chk("s1_tx_n1", tx, 1);
      chk("s1_busy_n1", busy, 1);
      @(negedge clock);
      chk("s1_tx_n2", tx, 0);
      k = 0;
      while (busy === 1'b1 && k < 1000) begin
         @(negedge clock);
         k++;
      end
      chk("s1_busy_len", k, 60 * CPB);
      tick();
      face_coords_ready = 1'b0;
      repeat (2) tick();
      check_rx("s1");

      // level held for 5 cycles -> one record
      r = $urandom; c = $urandom; p = 4'($urandom_range(0, 15));
      add_rec(r, c, p, 1'b0);
      pulse(r, c, p, 5);
      wait_idle("s2");
      check_rx("s2");

      // upper coordinate bits truncated
      p = 4'($urandom_range(0, 15));
      add_rec(32'h0001_0102, 32'hFFFF_0A0B, p, 1'b0);
      pulse(32'h0001_0102, 32'hFFFF_0A0B, p, 1);
      wait_idle("s3");
      check_rx("s3");

      // random single detections
      for (int i = 0; i < 4; i++) begin
         r = $urandom; c = $urandom; p = 4'($urandom_range(0, 15));
         add_rec(r, c, p, 1'b0);
         pulse(r, c, p, $urandom_range(1, 3));
         wait_idle("rnd");
         check_rx($sformatf("rnd%0d", i));
      end

      // random short burst, well within capacity
      for (int i = 0; i < 4; i++) begin
         r = $urandom; c = $urandom; p = 4'($urandom_range(0, 15));
         add_rec(r, c, p, 1'b0);
         pulse(r, c, p, 1);
         repeat ($urandom_range(0, 10)) tick();
      end
      wait_idle("burst");
      check_rx("burst");

      // 10 pulses 2 cycles apart: 10th dropped, 2nd record carries the flag
      for (int i = 0; i < 10; i++) begin
         r = $urandom; c = $urandom; p = 4'($urandom_range(0, 15));
         if (i < 9) add_rec(r, c, p, (i == 1));
         pulse(r, c, p, 1);
      end
      @(negedge clock);
      chk("s4_ovf_set", overflow, 1);
      wait_idle("s4");
      chk("s4_ovf_clr", overflow, 0);
      check_rx("s4");

      // reset during byte 3 DATA; ready held high through reset
      for (int i = 0; i < 2; i++) pulse($urandom, $urandom, 4'($urandom_range(0, 15)), 1);
      k = 0;
      @(negedge clock);
      while (tx !== 1'b0 && k < 100) begin
         @(negedge clock);
         k++;
      end
      chk("s5_start_timeout", (k >= 100), 0);
      repeat (3 * BYTE_CYC + CPB + 8) @(negedge clock);
      reset = 1'b1;
      face_coords_ready = 1'b1;
      @(negedge clock);
      chk("s5_tx_rst", tx, 1);
      chk("s5_busy_rst", busy, 0);
      tick();
      reset = 1'b0;
      zeros = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (tx !== 1'b1) zeros++;
      end
      chk("s5_no_start", zeros, 0);
      chk("s5_busy_after", busy, 0);
      tick();
      face_coords_ready = 1'b0;
      repeat (2) tick();
      rx_q.delete(); rx_t.delete(); exp_q.delete();
      r = $urandom; c = $urandom; p = 4'($urandom_range(0, 15));
      add_rec(r, c, p, 1'b0);
      pulse(r, c, p, 1);
      wait_idle("s5b");
      check_rx("s5b");

      // full FIFO, push coincides with STOP->START pop
      for (int i = 0; i < 9; i++) begin
         r = $urandom; c = $urandom; p = 4'($urandom_range(0, 15));
         add_rec(r, c, p, 1'b0);
         pulse(r, c, p, 1);
      end
      k = 0;
      while (rx_t.size() == 0 && k < 200) begin
         tick();
         k++;
      end
      chk("s6_first_byte_timeout", (k >= 200), 0);
      s = (rx_t.size() > 0) ? rx_t[0] : pcnt;
      k = 0;
      while (pcnt < s + 60 * CPB - 1 && k < 1000) begin
         tick();
         k++;
      end
      r = $urandom; c = $urandom; p = 4'($urandom_range(0, 15));
      add_rec(r, c, p, 1'b0);
      face_coords[0] = r;
      face_coords[1] = c;
      pyramid_number = p;
      face_coords_ready = 1'b1;
      tick();
      face_coords_ready = 1'b0;
      @(negedge clock);
      chk("s6_ovf", overflow, 0);
      wait_idle("s6");
      chk("s6_ovf_end", overflow, 0);
      chk("s6_nbytes_pre", rx_t.size(), 60);
      if (rx_t.size() == 60)
         chk("s6_contiguous", rx_t[59] - rx_t[0], 59 * BYTE_CYC);
      check_rx("s6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
